// File: rtl/ff_exp_seq_if.sv
// Request/result bundle for the GF(2^8) exponentiation sequencer.
// The master issues start with its operands; the slave returns busy, done and result.
interface ff_exp_seq_if #(
  parameter int EXP_W = 8
);
  logic             start;
  logic [7:0]       base_in;
  logic [EXP_W-1:0] exp_in;
  logic             busy;
  logic             done;
  logic [7:0]       result;

  modport master (
    output start, base_in, exp_in,
    input  busy, done, result
  );

  modport slave (
    input  start, base_in, exp_in,
    output busy, done, result
  );
endinterface

// File: rtl/ff_exp_seq.sv
// Constant-time GF(2^8) exponentiation: base^exp by left-to-right square-and-multiply,
// time-sharing one combinational field multiplier (polynomial 0x11B).
module ff_mult (
  input  logic [7:0] f_in,
  input  logic [7:0] p_in,
  output logic [7:0] p_out
);
  always_comb begin : mult_loop
    logic [7:0] shifted;
    p_out   = 8'h00;
    shifted = f_in;
    for (int i = 0; i < 8; i++) begin
      if (p_in[i]) p_out = p_out ^ shifted;
      // multiply by x, folding x^8 back in as x^4+x^3+x+1
      shifted = {shifted[6:0], 1'b0} ^ (shifted[7] ? 8'h1B : 8'h00);
    end
  end
endmodule

module ff_exp_seq #(
  parameter int EXP_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  ff_exp_seq_if.slave  bus
);
  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EXP_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [7:0]       acc_reg, acc_next;
  logic [7:0]       base_reg, base_next;
  logic [EXP_W-1:0] exp_reg, exp_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [7:0]       result_reg, result_next;
  logic             done_reg, done_next;

  logic [7:0] mult_f, mult_p, mult_out, mul_sel;

  ff_mult u_mult (
    .f_in  (mult_f),
    .p_in  (mult_p),
    .p_out (mult_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      acc_reg    <= 8'h00;
      base_reg   <= 8'h00;
      exp_reg    <= '0;
      idx_reg    <= '0;
      result_reg <= 8'h00;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      base_reg   <= base_next;
      exp_reg    <= exp_next;
      idx_reg    <= idx_next;
      result_reg <= result_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    base_next   = base_reg;
    exp_next    = exp_reg;
    idx_next    = idx_reg;
    result_next = result_reg;
    done_next   = 1'b0;
    mult_f      = acc_reg;
    mult_p      = acc_reg;
    // The multiply runs every MUL cycle; the exponent bit only steers this mux.
    mul_sel     = exp_reg[idx_reg] ? mult_out : acc_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          base_next  = bus.base_in;
          exp_next   = bus.exp_in;
          acc_next   = 8'h01;
          idx_next   = IDX_LAST;
          state_next = SQR;
        end
      end
      SQR: begin
        acc_next   = mult_out;
        state_next = MUL;
      end
      MUL: begin
        mult_p   = base_reg;
        acc_next = mul_sel;
        if (idx_reg != '0) begin
          idx_next   = idx_reg - IDX_ONE;
          state_next = SQR;
        end else begin
          result_next = mul_sel;
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy   = (state_reg == SQR) || (state_reg == MUL);
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
endmodule

// File: tb/tb_ff_exp_seq.sv
// Self-checking bench for ff_exp_seq: directed field vectors, timing invariance,
// start filtering, back-to-back starts, mid-operation reset and randomized operands.
module tb_ff_exp_seq;
  localparam int EXP_W = 8;
  localparam int LAT   = 2 * EXP_W;
  localparam int WAIT  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ff_exp_seq_if #(.EXP_W(EXP_W)) bus ();

  ff_exp_seq #(.EXP_W(EXP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: schoolbook carry-less product, then polynomial long division by 0x11B.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int bit_pos = 15; bit_pos >= 8; bit_pos--)
      if (prod[bit_pos]) prod = prod ^ (16'h011B << (bit_pos - 8));
    return prod[7:0];
  endfunction

  // Reference: base multiplied into 1, exp times.
  function automatic logic [7:0] ref_pow(input logic [7:0] b, input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = ref_mul(r, b);
    return r;
  endfunction

  // Drives one request and observes the window after acceptance. Operands are
  // scrambled right after acceptance; optional stray starts at cycles 3 and 9.
  task automatic run_op(input logic [7:0] b, input logic [7:0] e, input bit stray,
                        output logic [7:0] res, output int lat,
                        output int busy_cnt, output int done_cnt);
    res = 8'hxx; lat = -1; busy_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_in = b; bus.exp_in = e;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.base_in = 8'($urandom); bus.exp_in = 8'($urandom);
    if (bus.busy) busy_cnt++;
    for (int c = 1; c <= WAIT; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) begin lat = c; res = bus.result; end
      end
      if (bus.busy) busy_cnt++;
      if (stray && (c == 3 || c == 9)) begin
        bus.start = 1'b1; bus.base_in = 8'($urandom); bus.exp_in = 8'($urandom);
      end
    end
    $display("[TB] op base=%02h exp=%02h result=%02h latency=%0d busy=%0d dones=%0d",
             b, e, res, lat, busy_cnt, done_cnt);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.base_in = 8'h00; bus.exp_in = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 8'h00) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b result=%02h, required 0 0 00",
               bus.busy, bus.done, bus.result);
    end
    rst = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_directed();
    logic [7:0] bv [6] = '{8'h53, 8'h02, 8'h02, 8'h00, 8'h00, 8'h03};
    logic [7:0] ev [6] = '{8'hFE, 8'h08, 8'hFE, 8'h00, 8'hFE, 8'hFF};
    logic [7:0] xv [6] = '{8'hCA, 8'h1B, 8'h8D, 8'h01, 8'h00, 8'h01};
    logic [7:0] res; int lat, bc, dc;
    for (int i = 0; i < 6; i++) begin
      run_op(bv[i], ev[i], 1'b0, res, lat, bc, dc);
      tests++;
      if (res !== xv[i] || lat !== LAT || dc !== 1) begin
        fails++;
        $display("FAIL directed[%0d]: result=%02h latency=%0d dones=%0d, required %02h %0d 1",
                 i, res, lat, dc, xv[i], LAT);
      end
    end
  endtask

  task automatic test_constant_time();
    logic [7:0] b, r0, r1; int l0, l1, b0, b1, d0, d1;
    b = 8'($urandom_range(1, 255));
    run_op(b, 8'h00, 1'b0, r0, l0, b0, d0);
    run_op(b, 8'hFF, 1'b0, r1, l1, b1, d1);
    tests++;
    if (b0 !== LAT || b1 !== LAT) begin
      fails++;
      $display("FAIL const_busy: busy cycles %0d/%0d, required %0d", b0, b1, LAT);
    end
    tests++;
    if (l0 !== LAT || l1 !== LAT) begin
      fails++;
      $display("FAIL const_done: latency %0d/%0d, required %0d", l0, l1, LAT);
    end
    tests++;
    if (r0 !== 8'h01 || r1 !== ref_pow(b, 255)) begin
      fails++;
      $display("FAIL const_result: %02h/%02h, required 01/%02h", r0, r1, ref_pow(b, 255));
    end
  endtask

  task automatic test_ignore_start();
    logic [7:0] b, e, res; int lat, bc, dc;
    b = 8'($urandom); e = 8'($urandom);
    run_op(b, e, 1'b1, res, lat, bc, dc);
    tests++;
    if (dc !== 1 || lat !== LAT || res !== ref_pow(b, int'(e)) || bc !== LAT) begin
      fails++;
      $display("FAIL ignore_start: dones=%0d latency=%0d result=%02h busy=%0d, required 1 %0d %02h %0d",
               dc, lat, res, bc, 1, LAT, ref_pow(b, int'(e)), LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1, e1, b2, e2; int lat1, lat2;
    logic [7:0] r1, r2;
    b1 = 8'($urandom); e1 = 8'($urandom); b2 = 8'($urandom); e2 = 8'($urandom);
    lat1 = -1; lat2 = -1; r1 = 8'hxx; r2 = 8'hxx;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_in = b1; bus.exp_in = e1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= WAIT && lat1 < 0; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat1 = c; r1 = bus.result; end
    end
    bus.start = 1'b1; bus.base_in = b2; bus.exp_in = e2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", bus.busy, bus.done);
    end
    for (int c = 1; c <= WAIT && lat2 < 0; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat2 = c; r2 = bus.result; end
    end
    $display("[TB] b2b first=%02h^%02h=%02h (%0d) second=%02h^%02h=%02h (%0d)",
             b1, e1, r1, lat1, b2, e2, r2, lat2);
    tests++;
    if (lat1 !== LAT || lat2 !== LAT || r1 !== ref_pow(b1, int'(e1)) || r2 !== ref_pow(b2, int'(e2))) begin
      fails++;
      $display("FAIL b2b: latencies %0d/%0d results %02h/%02h, required %0d/%0d %02h/%02h",
               lat1, lat2, r1, r2, LAT, LAT, ref_pow(b1, int'(e1)), ref_pow(b2, int'(e2)));
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] res; int lat, bc, dc, dones;
    run_op(8'h02, 8'h08, 1'b0, res, lat, bc, dc);   // leaves result = 1B
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_in = 8'h53; bus.exp_in = 8'hFE;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid: busy=%b done=%b result=%02h, required 0 0 00",
               bus.busy, bus.done, bus.result);
    end
    dones = 0;
    for (int c = 0; c < WAIT; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    tests++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL rst_quiet: %0d active cycles after abort, required 0", dones);
    end
    $display("[TB] reset mid-operation checked");
    run_op(8'h53, 8'hFE, 1'b0, res, lat, bc, dc);
    tests++;
    if (res !== 8'hCA || lat !== LAT) begin
      fails++;
      $display("FAIL rst_restart: result=%02h latency=%0d, required CA %0d", res, lat, LAT);
    end
  endtask

  task automatic test_inverse_sweep();
    logic [7:0] res; int lat, bc, dc;
    for (int b = 0; b < 256; b++) begin
      run_op(8'(b), 8'hFE, 1'b0, res, lat, bc, dc);
      tests++;
      if (res !== ref_pow(8'(b), 254) || lat !== LAT) begin
        fails++;
        $display("FAIL inverse[%02h]: result=%02h latency=%0d, required %02h %0d",
                 b, res, lat, ref_pow(8'(b), 254), LAT);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b, e, res; int lat, bc, dc;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom); e = 8'($urandom);
      if (i % 8 == 0) b = 8'h00;
      run_op(b, e, 1'b0, res, lat, bc, dc);
      tests++;
      if (res !== ref_pow(b, int'(e)) || lat !== LAT || bc !== LAT || dc !== 1) begin
        fails++;
        $display("FAIL random[%0d]: %02h^%02h result=%02h latency=%0d busy=%0d dones=%0d, required %02h %0d %0d 1",
                 i, b, e, res, lat, bc, dc, ref_pow(b, int'(e)), LAT, LAT);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.base_in = 8'h00; bus.exp_in = 8'h00;
    test_reset();
    test_directed();
    test_constant_time();
    test_ignore_start();
    test_back_to_back();
    test_rst_mid();
    test_inverse_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
